uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo.sv | 125 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Byte FIFO feeding the UART transmitter. It uses a registered,
//               held pop output and registered empty/full/count outputs.
//               Optional sticky overflow/underflow flags are enabled by
//               defining UART_TX_FIFO_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int B = 8,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic [B-1:0] w_data,
    input  logic         rd,
    output logic [B-1:0] r_data,
    output logic         empty,
    output logic         full,
    output logic [W:0]   count,
    input  logic         err_clr,
    output logic         overflow,
    output logic         underflow
);

    localparam logic [W:0]   c_DEPTH   = {1'b1, {W{1'b0}}};
    localparam logic [W:0]   c_CNT_ONE = {{W{1'b0}}, 1'b1};
    localparam logic [W-1:0] c_PTR_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [B-1:0] r_mem [2**W];
    logic [W-1:0] r_wr_ptr;
    logic [W-1:0] r_rd_ptr;
    logic [W:0]   r_count;
    logic         r_empty;
    logic         r_full;
    logic [B-1:0] r_rdata;

    logic         w_push;
    logic         w_pop;
    logic [W:0]   w_count_next;

    // A push into a full FIFO is still legal when a pop frees the slot in
    // the same cycle.
    assign w_push = wr & (~r_full | rd);
    assign w_pop  = rd & ~r_empty;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop)
            w_count_next = r_count + c_CNT_ONE;
        else if (w_pop && !w_push)
            w_count_next = r_count - c_CNT_ONE;
    end

    // Storage is deliberately left uninitialised by reset.
    always_ff @(posedge clk) begin
        if (!reset && w_push)
            r_mem[r_wr_ptr] <= w_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_rdata  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop) begin
                r_rdata  <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count <= w_count_next;
            r_empty <= (w_count_next == '0);
            r_full  <= (w_count_next == c_DEPTH);
        end
    end

    assign r_data = r_rdata;
    assign empty  = r_empty;
    assign full   = r_full;
    assign count  = r_count;

`ifdef UART_TX_FIFO_ERR_EN
    logic r_overflow;
    logic r_underflow;
    logic w_ovf_evt;
    logic w_udf_evt;

    assign w_ovf_evt = wr & r_full & ~rd;
    assign w_udf_evt = rd & r_empty;

    // A new event takes priority over a coincident clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_evt)
                r_overflow <= 1'b1;
            else if (err_clr)
                r_overflow <= 1'b0;
            if (w_udf_evt)
                r_underflow <= 1'b1;
            else if (err_clr)
                r_underflow <= 1'b0;
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    logic w_unused_err_clr;
    assign w_unused_err_clr = err_clr;
    assign overflow         = 1'b0;
    assign underflow        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Self-checking bench for uart_tx_fifo. It uses a queue-based
//               reference model and combines directed and random steps.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int B     = 8;
    localparam int W     = 4;
    localparam int DEPTH = 2**W;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         wr = 1'b0;
    logic [B-1:0] w_data = '0;
    logic         rd = 1'b0;
    logic         err_clr = 1'b0;
    logic [B-1:0] r_data;
    logic         empty;
    logic         full;
    logic [W:0]   count;
    logic         overflow;
    logic         underflow;

    uart_tx_fifo #(.B(B), .W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr        (wr),
        .w_data    (w_data),
        .rd        (rd),
        .r_data    (r_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .err_clr   (err_clr),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [B-1:0] m_q[$];
    logic [B-1:0] m_rdata = '0;
    logic         m_ovf = 1'b0;
    logic         m_udf = 1'b0;

    int n_checks = 0;
    int n_fails  = 0;
    int max_cnt  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"},     32'(count),     32'(m_q.size()));
        chk({tag, ".empty"},     32'(empty),     32'(m_q.size() == 0));
        chk({tag, ".full"},      32'(full),      32'(m_q.size() == DEPTH));
        chk({tag, ".r_data"},    32'(r_data),    32'(m_rdata));
        chk({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
        chk({tag, ".underflow"}, 32'(underflow), 32'(m_udf));
    endtask

    // One clock: drive, advance model from pre-edge state, then sample 1 time unit later.
    task automatic step(input logic s_rst, input logic s_wr, input logic [B-1:0] s_d,
                        input logic s_rd, input logic s_clr);
        int  sz;
        logic ovf_evt, udf_evt, push_ok, pop_ok;
        reset = s_rst; wr = s_wr; w_data = s_d; rd = s_rd; err_clr = s_clr;
        @(posedge clk);
        sz      = m_q.size();
        push_ok = s_wr && (sz < DEPTH || s_rd);
        pop_ok  = s_rd && sz > 0;
        ovf_evt = s_wr && sz == DEPTH && !s_rd;
        udf_evt = s_rd && sz == 0;
        if (s_rst) begin
            m_q.delete();
            m_rdata = '0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (pop_ok)  m_rdata = m_q.pop_front();
            if (push_ok) m_q.push_back(s_d);
`ifdef UART_TX_FIFO_ERR_EN
            if (ovf_evt) m_ovf = 1'b1; else if (s_clr) m_ovf = 1'b0;
            if (udf_evt) m_udf = 1'b1; else if (s_clr) m_udf = 1'b0;
`else
            m_ovf = ovf_evt & 1'b0;
            m_udf = udf_evt & 1'b0;
`endif
        end
        if (m_q.size() > max_cnt) max_cnt = m_q.size();
        #1;
        reset = 1'b0; wr = 1'b0; rd = 1'b0; err_clr = 1'b0;
    endtask

    task automatic push(input logic [B-1:0] d);
        step(1'b0, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic pop();
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        int budget;
        logic [B-1:0] dat;
        logic [B-1:0] seen[$];

        // Reset held two clocks, then idle
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h99, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        check_all("reset");

        // Single word, then r_data held across further pushes
        push(8'hA5);
        check_all("single_push");
        pop();
        check_all("single_pop");
        chk("single_rdata", 32'(r_data), 32'h A5);
        for (int i = 0; i < 3; i++) begin
            push(8'h10 + 8'(i));
            check_all("hold_rdata");
        end
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        check_all("reset_midstream");

        // Fill, drop, drain in order
        for (int i = 0; i < DEPTH; i++) push(8'(i));
        check_all("fill");
        chk("fill_full", 32'(full), 32'd1);
        push(8'hFF);
        check_all("drop_push");
        for (int i = 0; i < DEPTH; i++) begin
            pop();
            chk("drain_order", 32'(r_data), 32'(i));
        end
        check_all("drained");
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        check_all("clr1");

        // Wrap-around: 8 rounds of push 5 / pop 5
        max_cnt = 0;
        dat = 8'h40;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 5; i++) begin push(dat); dat++; end
            for (int i = 0; i < 5; i++) begin
                pop();
                check_all("wrap");
            end
        end
        chk("wrap_maxcnt", 32'(max_cnt), 32'd5);

        // Simultaneous push/pop while full
        for (int i = 0; i < DEPTH; i++) push(8'h80 + 8'(i));
        step(1'b0, 1'b1, 8'h77, 1'b1, 1'b0);
        check_all("full_wr_rd");
        chk("full_wr_rd_oldest", 32'(r_data), 32'h80);
        for (int i = 0; i < DEPTH; i++) pop();
        check_all("full_wr_rd_drain");
        chk("last_is_77", 32'(r_data), 32'h77);

        // Simultaneous push/pop while empty
        step(1'b0, 1'b1, 8'h3C, 1'b1, 1'b0);
        check_all("empty_wr_rd");
        pop();
        check_all("empty_wr_rd_next");
        chk("rdata_3c", 32'(r_data), 32'h3C);

        // Loopback: transmitter-like consumer pops whenever tx_start (= ~empty) is seen
        push(8'h55);
        push(8'hC3);
        budget = 200;
        while (!empty && budget > 0) begin
            for (int k = 0; k < 4; k++) step(1'b0, 1'b0, '0, 1'b0, 1'b0);
            pop();
            seen.push_back(r_data);
            budget--;
        end
        chk("loop_timeout", 32'(budget > 0), 32'd1);
        chk("loop_n", 32'(seen.size()), 32'd2);
        if (seen.size() == 2) begin
            chk("loop_w0", 32'(seen[0]), 32'h55);
            chk("loop_w1", 32'(seen[1]), 32'hC3);
        end
        check_all("loop_empty");
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check_all("loop_udf");
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        check_all("loop_clr");

        // Random traffic, occasional reset, set-vs-clear collisions included
        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 99) < 55,
                 8'($urandom),
                 $urandom_range(0, 99) < 45,
                 $urandom_range(0, 99) < 8);
            check_all("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
